// File: rtl/of_drain_pkg.sv
// of_drain_pkg: shared types and the per-channel post-processing function for of_drain.
//
// Build option:
//   OF_DRAIN_RELU_EN  defined   -> ReLU followed by unsigned saturation to 0..255.
//                     undefined -> signed saturation to 8-bit two's complement.
//
// Contents:
//   ser_state_e  serializer state (StIdle, StEmit)
//   elem_t       one 8-bit output element; the top builds its pixel word as elem_t [CHANNEL-1:0]
//   post_proc()  clamps one sign-extended accumulator value to an 8-bit element
package of_drain_pkg;

   typedef enum logic {
      StIdle,
      StEmit
   } ser_state_e;

   typedef logic [7:0] elem_t;

   // Accumulators are sign-extended to this width before post-processing, so one
   // function serves every BITWIDTH up to 64.
   localparam int unsigned AccExtBits = 64;

   function automatic elem_t post_proc(input logic signed [AccExtBits-1:0] acc);
      elem_t res;
`ifdef OF_DRAIN_RELU_EN
      if (acc < 64'sd0) begin
         res = 8'h00;
      end else if (acc > 64'sd255) begin
         res = 8'hFF;
      end else begin
         res = acc[7:0];
      end
`else
      if (acc > 64'sd127) begin
         res = 8'h7F;
      end else if (acc < -64'sd128) begin
         res = 8'h80;
      end else begin
         res = acc[7:0];
      end
`endif
      return res;
   endfunction

endpackage

// File: rtl/of_fifo.sv
// of_fifo: single-clock synchronous FIFO with first-word-fall-through read data.
//
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset (empties the FIFO)
//   wr_en_i   push request; accepted when not full, or when full and popping in the same cycle
//   wdata_i   push data
//   rd_en_i   pop request; ignored when empty
//   rdata_o   head-of-queue data, valid whenever empty_o is low
//   full_o    no free slots
//   empty_o   no stored entries
//   free_o    number of free slots (0..Depth)
module of_fifo #(
   parameter int unsigned Width = 24,
   parameter int unsigned Depth = 16,
   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_en_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             rd_en_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AddrW:0]   free_o
);

   localparam logic [AddrW:0] DepthC = (AddrW + 1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wptr_q, wptr_d;
   logic [AddrW-1:0] rptr_q, rptr_d;
   logic [AddrW:0]   count_q, count_d;
   logic             do_wr, do_rd;

   assign full_o  = (count_q == DepthC);
   assign empty_o = (count_q == '0);
   assign free_o  = DepthC - count_q;
   assign rdata_o = mem_q[rptr_q];

   // A full FIFO is never empty, so a pop in the same cycle frees the slot the push needs.
   assign do_rd = rd_en_i && !empty_o;
   assign do_wr = wr_en_i && (!full_o || rd_en_i);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_wr) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (do_rd) begin
         rptr_d = rptr_q + 1'b1;
      end
      unique case ({do_wr, do_rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk_i) begin
      if (do_wr) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/of_drain.sv
// of_drain: output-feature drain at the bottom edge of the systolic array.
//
// Receives CHANNEL column results skewed diagonally (column k lags column 0 by k cycles),
// re-aligns them into one pixel word, clamps each channel to 8 bits, buffers pixel words in
// a FIFO and serializes them one element per cycle in (y, x, c) raster order.
//
// Build option: OF_DRAIN_RELU_EN selects ReLU + unsigned saturation; otherwise signed
// saturation (see of_drain_pkg::post_proc).
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset; clears all state, data and sticky flags
//   i_data      per-column partial sums (signed), skewed
//   i_valid     per-column valids, skewed identically
//   o_ready     upstream may launch a new pixel (column 0) next cycle
//   o_data      serialized output element
//   o_valid     element strobe, no backpressure
//   o_done      one-cycle pulse after the last element of a frame
//   o_overflow  sticky: a pixel word was dropped because the FIFO was full
//   o_skew_err  sticky: a column valid disagreed with column 0 after de-skew
module of_drain
   import of_drain_pkg::*;
#(
   parameter int unsigned WIDTH      = 128,
   parameter int unsigned HEIGHT     = 128,
   parameter int unsigned CHANNEL    = 3,
   parameter int unsigned BITWIDTH   = 16,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [CHANNEL-1:0][BITWIDTH-1:0]   i_data,
   input  logic [CHANNEL-1:0]                 i_valid,
   output logic                               o_ready,
   output logic [7:0]                         o_data,
   output logic                               o_valid,
   output logic                               o_done,
   output logic                               o_overflow,
   output logic                               o_skew_err
);

   typedef elem_t [CHANNEL-1:0] pix_t;

   localparam int unsigned PixBits = CHANNEL * 8;
   localparam int unsigned FreeW   = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
   localparam int unsigned ChW     = (CHANNEL > 1) ? $clog2(CHANNEL) : 1;
   localparam int unsigned Frame   = WIDTH * HEIGHT;
   localparam int unsigned PixW    = (Frame > 1) ? $clog2(Frame) : 1;

   localparam logic [FreeW-1:0] ReadyThresh = FreeW'(CHANNEL + 1);
   localparam logic [ChW-1:0]   LastCh      = ChW'(CHANNEL - 1);
   localparam logic [PixW-1:0]  LastPix     = PixW'(Frame - 1);

   // ---------------------------------------------------------------------------------------
   // De-skew: column k is delayed CHANNEL-1-k cycles so all columns meet in the cycle the
   // last column arrives.
   // ---------------------------------------------------------------------------------------
   logic [BITWIDTH-1:0] al_data [CHANNEL];
   logic [CHANNEL-1:0]  al_valid;

   for (genvar k = 0; k < CHANNEL; k++) begin : g_col
      localparam int unsigned Dly = CHANNEL - 1 - k;
      if (Dly == 0) begin : g_pass
         assign al_data[k]  = i_data[k];
         assign al_valid[k] = i_valid[k];
      end else begin : g_dly
         logic [Dly-1:0][BITWIDTH-1:0] data_q;
         logic [Dly-1:0]               valid_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               data_q  <= '0;
               valid_q <= '0;
            end else begin
               data_q[0]  <= i_data[k];
               valid_q[0] <= i_valid[k];
               for (int j = 1; j < int'(Dly); j++) begin
                  data_q[j]  <= data_q[j-1];
                  valid_q[j] <= valid_q[j-1];
               end
            end
         end

         assign al_data[k]  = data_q[Dly-1];
         assign al_valid[k] = valid_q[Dly-1];
      end
   end

   logic skew_mis;
   assign skew_mis = |(al_valid ^ {CHANNEL{al_valid[0]}});

   pix_t clamp_word;
   always_comb begin
      clamp_word = '0;
      for (int k = 0; k < int'(CHANNEL); k++) begin
         clamp_word[k] = post_proc({{(AccExtBits - BITWIDTH){al_data[k][BITWIDTH-1]}},
                                    al_data[k]});
      end
   end

   // ---------------------------------------------------------------------------------------
   // Staging register and FIFO
   // ---------------------------------------------------------------------------------------
   pix_t              stage_q;
   logic              stage_vld_q;
   logic              fifo_full, fifo_empty, pop;
   logic [PixBits-1:0] fifo_rdata;
   logic [FreeW-1:0]  fifo_free;

   of_fifo #(
      .Width (PixBits),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .wr_en_i (stage_vld_q),
      .wdata_i (stage_q),
      .rd_en_i (pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .free_o  (fifo_free)
   );

   logic overflow_q, skew_err_q, ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_q     <= '0;
         stage_vld_q <= 1'b0;
         overflow_q  <= 1'b0;
         skew_err_q  <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         // A skew mismatch is flagged but the word is still taken if column 0 is valid.
         stage_q     <= clamp_word;
         stage_vld_q <= al_valid[0];
         if (skew_mis) begin
            skew_err_q <= 1'b1;
         end
         if (stage_vld_q && fifo_full && !pop) begin
            overflow_q <= 1'b1;
         end
         // Headroom for every skewed pixel already launched plus the staging register.
         ready_q <= (fifo_free >= ReadyThresh);
      end
   end

   // ---------------------------------------------------------------------------------------
   // Serializer and frame counter
   // ---------------------------------------------------------------------------------------
   ser_state_e      state_q, state_d;
   logic [ChW-1:0]  ch_q, ch_d;
   pix_t            word_q, word_d;
   logic [PixW-1:0] pix_q, pix_d;
   logic            done_q, done_d;

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      word_d  = word_q;
      pix_d   = pix_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               word_d  = fifo_rdata;
               ch_d    = '0;
               state_d = StEmit;
            end
         end
         StEmit: begin
            if (ch_q == LastCh) begin
               if (pix_q == LastPix) begin
                  pix_d  = '0;
                  done_d = 1'b1;
               end else begin
                  pix_d = pix_q + 1'b1;
               end
               ch_d = '0;
               // Fetch the next word now so consecutive pixels leave without a bubble.
               if (!fifo_empty) begin
                  pop    = 1'b1;
                  word_d = fifo_rdata;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               ch_d = ch_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ch_q    <= '0;
         word_q  <= '0;
         pix_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         word_q  <= word_d;
         pix_q   <= pix_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      o_valid = (state_q == StEmit);
      o_data  = 8'h00;
      if (state_q == StEmit) begin
         o_data = word_q[ch_q];
      end
   end

   assign o_ready    = ready_q;
   assign o_done     = done_q;
   assign o_overflow = overflow_q;
   assign o_skew_err = skew_err_q;

endmodule
